// File: rtl/led_mode_ctrl.sv
// led_mode_ctrl: pushbutton debounce, PULSE clock divider and one-hot mode sequencer.
// Define LED_CTRL_SPEED_EN to build the KEY_SPEED path, SPEED register and variable divider.
module led_mode_ctrl #(
    parameter int NUM_MODES   = 4,
    parameter int DIV_BASE    = 3_125_000,
    parameter int DEB_CYCLES  = 1_000_000,
    parameter int HOLD_CYCLES = 50_000_000
) (
    input  logic                 CLK,
    input  logic                 RESET,
    input  logic                 KEY_NEXT,
    input  logic                 KEY_SPEED,
    output logic                 PULSE,
    output logic [NUM_MODES-1:0] MODE_ON,
    output logic [2:0]           MODE_IDX,
    output logic                 ACTIVE,
    output logic [1:0]           SPEED
);
    localparam int DEB_W  = $clog2(DEB_CYCLES + 1);
    localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);
    localparam int DIV_W  = $clog2(DIV_BASE * 8 + 1);

    localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEB_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(HOLD_CYCLES);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
    localparam logic [2:0]        LAST_MODE = 3'(NUM_MODES - 1);

    typedef enum logic [1:0] {S_IDLE, S_GAP, S_RUN} state_t;

    logic              next_s1, next_s2, next_deb;
    logic [DEB_W-1:0]  next_cnt;
    logic [HOLD_W-1:0] hold_cnt;
    logic              short_evt, long_evt;
    logic [DIV_W-1:0]  div_cnt, half_last;
    logic              pulse_prev, pulse_rise;
    state_t            state, state_nx;
    logic [2:0]        tgt, tgt_nx;
    logic              tgt_idle, tgt_idle_nx;
    logic [1:0]        gap_cnt, gap_nx;
    logic [NUM_MODES-1:0] mode_nx;

    function automatic logic [2:0] next_mode(input logic [2:0] m);
        return (m == LAST_MODE) ? 3'd0 : m + 3'd1;
    endfunction

    // KEY_NEXT: synchroniser, then level accepted only after DEB_CYCLES stable cycles
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            next_s1  <= 1'b1;
            next_s2  <= 1'b1;
            next_deb <= 1'b1;
            next_cnt <= '0;
        end else begin
            next_s1 <= KEY_NEXT;
            next_s2 <= next_s1;
            if (next_s2 == next_deb) begin
                next_cnt <= '0;
            end else if (next_cnt == DEB_LAST) begin
                next_deb <= next_s2;
                next_cnt <= '0;
            end else begin
                next_cnt <= next_cnt + DEB_W'(1);
            end
        end
    end

    // Hold counter saturates at HOLD_CYCLES so a long press never also yields a short event
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            hold_cnt  <= '0;
            short_evt <= 1'b0;
            long_evt  <= 1'b0;
        end else if (!next_deb) begin
            short_evt <= 1'b0;
            long_evt  <= (hold_cnt == HOLD_LAST);
            if (hold_cnt != HOLD_MAX) begin
                hold_cnt <= hold_cnt + HOLD_W'(1);
            end
        end else begin
            short_evt <= (hold_cnt != '0) && (hold_cnt != HOLD_MAX);
            long_evt  <= 1'b0;
            hold_cnt  <= '0;
        end
    end

`ifdef LED_CTRL_SPEED_EN
    logic             spd_s1, spd_s2, spd_deb, spd_prev, speed_evt;
    logic [DEB_W-1:0] spd_cnt;
    logic [1:0]       speed_q;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            spd_s1    <= 1'b1;
            spd_s2    <= 1'b1;
            spd_deb   <= 1'b1;
            spd_prev  <= 1'b1;
            spd_cnt   <= '0;
            speed_evt <= 1'b0;
            speed_q   <= 2'd0;
        end else begin
            spd_s1    <= KEY_SPEED;
            spd_s2    <= spd_s1;
            spd_prev  <= spd_deb;
            speed_evt <= spd_prev & ~spd_deb;
            if (speed_evt) begin
                speed_q <= speed_q + 2'd1;
            end
            if (spd_s2 == spd_deb) begin
                spd_cnt <= '0;
            end else if (spd_cnt == DEB_LAST) begin
                spd_deb <= spd_s2;
                spd_cnt <= '0;
            end else begin
                spd_cnt <= spd_cnt + DEB_W'(1);
            end
        end
    end

    assign SPEED = speed_q;
`else
    logic unused_key_speed;
    assign unused_key_speed = KEY_SPEED;
    assign SPEED = 2'd0;
`endif

    // ">=" rather than "==" so a speed decrease cannot leave the counter stranded above H-1
    assign half_last  = (DIV_W'(DIV_BASE) << SPEED) - DIV_W'(1);
    assign pulse_rise = PULSE & ~pulse_prev;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            div_cnt    <= '0;
            PULSE      <= 1'b0;
            pulse_prev <= 1'b0;
        end else begin
            pulse_prev <= PULSE;
            if (div_cnt >= half_last) begin
                div_cnt <= '0;
                PULSE   <= ~PULSE;
            end else begin
                div_cnt <= div_cnt + DIV_W'(1);
            end
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state    <= S_IDLE;
            tgt      <= 3'd0;
            tgt_idle <= 1'b1;
            gap_cnt  <= 2'd0;
            MODE_ON  <= '0;
        end else begin
            state    <= state_nx;
            tgt      <= tgt_nx;
            tgt_idle <= tgt_idle_nx;
            gap_cnt  <= gap_nx;
            MODE_ON  <= mode_nx;
        end
    end

    // Leaving GAP on the second rise itself puts MODE_ON up one CLK after that rise
    always_comb begin
        state_nx    = state;
        tgt_nx      = tgt;
        tgt_idle_nx = tgt_idle;
        gap_nx      = gap_cnt;
        case (state)
            S_IDLE: begin
                if (short_evt) begin
                    tgt_nx      = 3'd0;
                    tgt_idle_nx = 1'b0;
                    gap_nx      = 2'd0;
                    state_nx    = S_GAP;
                end
            end
            S_GAP: begin
                if (short_evt) begin
                    tgt_nx      = tgt_idle ? 3'd0 : next_mode(tgt);
                    tgt_idle_nx = 1'b0;
                end else if (long_evt) begin
                    tgt_idle_nx = 1'b1;
                end
                if (pulse_rise) begin
                    gap_nx = gap_cnt + 2'd1;
                    if (gap_cnt == 2'd1) begin
                        state_nx = tgt_idle_nx ? S_IDLE : S_RUN;
                    end
                end
            end
            S_RUN: begin
                if (short_evt) begin
                    tgt_nx   = next_mode(tgt);
                    gap_nx   = 2'd0;
                    state_nx = S_GAP;
                end else if (long_evt) begin
                    tgt_idle_nx = 1'b1;
                    gap_nx      = 2'd0;
                    state_nx    = S_GAP;
                end
            end
            default: state_nx = S_IDLE;
        endcase
        mode_nx = (state_nx == S_RUN) ? (NUM_MODES'(1) << tgt_nx) : '0;
    end

    assign MODE_IDX = tgt_idle ? 3'd0 : tgt;
    assign ACTIVE   = (state == S_RUN);

endmodule
